// File: rtl/aes_decipher_iter.sv
// rtl/aes_decipher_iter.sv - iterative AES decipher, SBOX_LANES inverse S-boxes per cycle
// Define AES_DECIPHER_KEYLEN192_EN to build the AES-192 (Nr=12) key length.
module aes_decipher_iter #(
  parameter int SBOX_LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic [1:0]   keylen,
  output logic [3:0]   round_key_addr,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  localparam int S     = 16 / SBOX_LANES;
  localparam int CTR_W = $clog2(S);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, ROUND} state_t;

  state_t             r_state;
  logic [127:0]       r_block;
  logic [3:0]         r_nr;
  logic [3:0]         r_round_ctr;
  logic [CTR_W-1:0]   r_sbox_ctr;
  logic [3:0]         r_addr;
  logic               r_ready;

  logic [3:0]         w_nr_sel;
  logic [127:0]       w_sub;
  logic [127:0]       w_shift;
  logic [127:0]       w_ark;
  logic [127:0]       w_mix;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse affine map followed by the field inverse x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    logic [7:0] p;
    logic [7:0] r;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] imc_coef(input int k);
    logic [7:0] c;
    case (k)
      0:       c = 8'h0e;
      1:       c = 8'h0b;
      2:       c = 8'h0d;
      default: c = 8'h09;
    endcase
    return c;
  endfunction

  always_comb begin
    w_nr_sel = 4'd10;
    if (keylen == 2'b10) w_nr_sel = 4'd14;
`ifdef AES_DECIPHER_KEYLEN192_EN
    else if (keylen == 2'b01) w_nr_sel = 4'd12;
`endif
  end

  always_comb begin
    int base;
    base  = int'(r_sbox_ctr) * SBOX_LANES;
    w_sub = r_block;
    for (int l = 0; l < SBOX_LANES; l++)
      w_sub[127-8*(base+l) -: 8] = inv_sbox(r_block[127-8*(base+l) -: 8]);
  end

  // Row r of the state rotates right by r columns.
  always_comb begin
    logic [7:0] acc;
    w_shift = '0;
    w_mix   = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_shift[127-8*(4*c+r) -: 8] = r_block[127-8*(4*((c-r+4)%4)+r) -: 8];
    w_ark = w_shift ^ round_key;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(imc_coef((k-r+4)%4), w_ark[127-8*(4*c+k) -: 8]);
        w_mix[127-8*(4*c+r) -: 8] = acc;
      end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_block     <= '0;
      r_nr        <= 4'd10;
      r_round_ctr <= '0;
      r_sbox_ctr  <= '0;
      r_addr      <= '0;
      r_ready     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (next) begin
            r_block     <= block;
            r_nr        <= w_nr_sel;
            r_round_ctr <= w_nr_sel;
            r_addr      <= w_nr_sel;
            r_ready     <= 1'b0;
            r_state     <= INIT;
          end
        end
        INIT: begin
          r_block     <= r_block ^ round_key;
          r_round_ctr <= r_nr - 4'd1;
          r_sbox_ctr  <= '0;
          r_addr      <= '0;
          r_state     <= SBOX;
        end
        SBOX: begin
          r_block <= w_sub;
          if (r_sbox_ctr == CTR_W'(S-1)) begin
            r_sbox_ctr <= '0;
            r_addr     <= r_round_ctr;
            r_state    <= ROUND;
          end else begin
            r_sbox_ctr <= r_sbox_ctr + 1'b1;
          end
        end
        ROUND: begin
          r_addr <= '0;
          if (r_round_ctr != 4'd0) begin
            r_block     <= w_mix;
            r_round_ctr <= r_round_ctr - 4'd1;
            r_sbox_ctr  <= '0;
            r_state     <= SBOX;
          end else begin
            r_block <= w_ark;
            r_ready <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign round_key_addr = r_addr;
  assign new_block      = r_block;
  assign ready          = r_ready;

endmodule
